spi_flash_resp: RTL and testbench
=================================

Name: spi_flash_resp

Overview:
- Synthesizable SPI-flash responder (slave) that answers the erase-path commands our flash controllers issue: WREN, WRDI, RDSR, BE, RDID.
- Serves as the far end of the SPI link for on-board loopback tests and as a bench model for the erase/write controllers.
- Oversamples cs_n/sck/mosi with sys_clk, SPI mode 0, MSB first.
- Models WEL/WIP status bits and a timed bulk erase.

Parameters:
BE_CYCLES, 32'd500, sys_clk cycles WIP stays high after an accepted BE (range 1..2^32-1).
ID_CODE, 24'h202015, 3-byte JEDEC ID returned by RDID, MSB byte first.

Ports:
sys_clk    input   1  system clock; must be >= 4x sck frequency
sys_rst    input   1  asynchronous reset, active-high
cs_n       input   1  SPI chip select, active-low, asynchronous to sys_clk
sck        input   1  SPI clock, idle low (mode 0)
mosi       input   1  SPI data in
miso       output  1  SPI data out, always driven (no tri-state)
wel        output  1  write-enable latch status
wip        output  1  erase-in-progress status
be_done    output  1  one-cycle pulse when a bulk erase completes
cmd_valid  output  1  one-cycle pulse when a full command byte is received
cmd_byte   output  8  last received command byte, held until next cmd_valid

Behaviour:
- Reset (sys_rst=1, asynchronous): miso=0, wel=0, wip=0, be_done=0, cmd_valid=0, cmd_byte=8'h00, erase counter=0, state IDLE, all synchronizers cleared to cs_n=1, sck=0, mosi=0.
- Input synchronization: cs_n, sck and mosi each pass through 2 flops, then one delay flop.
  - sck_rise = s1&~s2 and sck_fall = ~s1&s2, each from the synchronized samples.
  - cs_rise is detected the same way on cs_n.
  - All actions occur 3 sys_clk cycles after the pin edge.
- States: IDLE, CMD, RESP, IGNORE.
  - IDLE: synchronized cs_n=0 -> CMD, bit_cnt=0.
  - CMD: on each sck_rise, shift mosi into shift_reg MSB-first and increment bit_cnt.
  - 8th rise: cmd_byte<=byte, cmd_valid=1 for one cycle, then decode:
    - RDSR 8'h05 -> RESP, load {6'b0, wel, wip}.
    - RDID 8'h9F -> RESP, load ID_CODE.
    - WREN 8'h06, WRDI 8'h04, BE 8'hC7 -> stay in CMD, awaiting cs_rise with bit_cnt==8.
    - Any other byte -> IGNORE.
  - RESP: on each sck_fall, miso<=next bit, MSB first.
    - RDSR reloads status every 8 bits, so status streams continuously with live values.
    - RDID shifts out 24 bits, then miso=0.
  - IGNORE: miso=0, all sck edges discarded.
  - Any state: synchronized cs_n=1 -> IDLE, bit_cnt=0, miso=0.
- Command execution on cs_rise is valid only if bit_cnt==8 exactly and the state is CMD. Otherwise no effect, including 9+ bits or an aborted byte.
  - WREN: wel<=1 when wip=0.
  - WRDI: wel<=0 when wip=0.
  - BE: when wel=1 and wip=0, wip<=1 and counter<=BE_CYCLES. Otherwise ignored.
- While wip=1, only RDSR and RDID respond. WREN, WRDI and BE are decoded (cmd_valid still pulses) but not executed.
- Erase timer: decrements once per sys_clk while wip=1. At count 1 -> 0, in the same cycle: wip<=0, wel<=0, be_done=1 for one cycle.
- Status sampled for RDSR is the registered value at the load cycle. A bit completing mid-byte appears in the next byte.
- Reset mid-erase: wip, wel and the counter clear immediately; no be_done pulse.
- cs_n glitch shorter than the sync window may be missed; not required to detect.

Test Plan:
- WREN (8'h06, cs_n high after 8 bits) -> cmd_valid pulse with cmd_byte=8'h06; wel=1 ~3 cycles after cs_n rises; wip=0.
- WREN, then BE 8'hC7 with BE_CYCLES=500 -> wip=1 for exactly 500 sys_clk; then wip=0, wel=0, and be_done high for 1 cycle.
- BE without a prior WREN -> wip stays 0, no be_done, cmd_byte=8'hC7.
- RDSR held for 24 sck during an erase -> miso bytes 8'h03, 8'h03, 8'h03. After completion, a new RDSR returns 8'h00.
- RDID for 40 sck -> miso 8'h20, 8'h20, 8'h15, then 8'h00, 8'h00; sck_div=4, sck=12.5 MHz at sys_clk=50 MHz.
- Edge cases:
  - WREN followed by a 9th sck before cs_n rises -> wel stays 0.
  - sys_rst asserted at cycle 200 of an erase -> wip=0 and wel=0 asynchronously; no be_done.

Source files
------------

// File: rtl/spi_flash_resp.sv
// SPI-flash responder (mode 0, MSB first) oversampled by sys_clk: WREN/WRDI/RDSR/BE/RDID.
// Models the WEL/WIP status bits and a bulk erase that lasts BE_CYCLES sys_clk cycles.
module spi_flash_resp #(
  parameter logic [31:0] BE_CYCLES = 32'd500,
  parameter logic [23:0] ID_CODE   = 24'h202015
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       cs_n,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       wel,
  output logic       wip,
  output logic       be_done,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte
);

  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_BE   = 8'hC7;

  typedef enum logic [1:0] {IDLE, CMD, RESP, IGNORE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cs_sync_q, sck_sync_q;
  logic [1:0]  mosi_sync_q;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [23:0] tx_q, tx_d;
  logic [2:0]  out_cnt_q, out_cnt_d;
  logic        rdsr_q, rdsr_d;
  logic        miso_q, miso_d;
  logic        wel_q, wel_d;
  logic        wip_q, wip_d;
  logic        be_done_q, be_done_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic [31:0] ecnt_q, ecnt_d;

  logic       cs_s1, cs_rise, sck_rise, sck_fall, mosi_s;
  logic [7:0] rx_byte, status;

  // Index 1 is the synchronized sample, index 2 the one-cycle-delayed copy.
  assign cs_s1    = cs_sync_q[1];
  assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign mosi_s   = mosi_sync_q[1];
  assign rx_byte  = {shift_q, mosi_s};
  assign status   = {6'b0, wel_q, wip_q};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cs_sync_q   <= 3'b111;
      sck_sync_q  <= 3'b000;
      mosi_sync_q <= 2'b00;
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 7'd0;
      tx_q        <= 24'd0;
      out_cnt_q   <= 3'd0;
      rdsr_q      <= 1'b0;
      miso_q      <= 1'b0;
      wel_q       <= 1'b0;
      wip_q       <= 1'b0;
      be_done_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= 8'h00;
      ecnt_q      <= 32'd0;
    end else begin
      cs_sync_q   <= {cs_sync_q[1:0], cs_n};
      sck_sync_q  <= {sck_sync_q[1:0], sck};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      out_cnt_q   <= out_cnt_d;
      rdsr_q      <= rdsr_d;
      miso_q      <= miso_d;
      wel_q       <= wel_d;
      wip_q       <= wip_d;
      be_done_q   <= be_done_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
      ecnt_q      <= ecnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    out_cnt_d   = out_cnt_q;
    rdsr_d      = rdsr_q;
    miso_d      = miso_q;
    wel_d       = wel_q;
    wip_d       = wip_q;
    be_done_d   = 1'b0;
    cmd_valid_d = 1'b0;
    cmd_byte_d  = cmd_byte_q;
    ecnt_d      = ecnt_q;

    if (wip_q) begin
      ecnt_d = ecnt_q - 32'd1;
      if (ecnt_q == 32'd1) begin
        wip_d     = 1'b0;
        wel_d     = 1'b0;
        be_done_d = 1'b1;
      end
    end

    // Write-type commands only take effect when cs_n closes exactly after one byte.
    if (cs_rise && state_q == CMD && bit_cnt_q == 4'd8 && !wip_q) begin
      case (cmd_byte_q)
        OP_WREN: wel_d = 1'b1;
        OP_WRDI: wel_d = 1'b0;
        OP_BE: begin
          if (wel_q) begin
            wip_d  = 1'b1;
            ecnt_d = BE_CYCLES;
          end
        end
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (!cs_s1) begin
          state_d   = CMD;
          bit_cnt_d = 4'd0;
        end
      end
      CMD: begin
        if (sck_rise) begin
          shift_d = rx_byte[6:0];
          if (bit_cnt_q != 4'hF) bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            cmd_valid_d = 1'b1;
            cmd_byte_d  = rx_byte;
            case (rx_byte)
              OP_RDSR: begin
                state_d   = RESP;
                tx_d      = {status, 16'h0000};
                rdsr_d    = 1'b1;
                out_cnt_d = 3'd0;
              end
              OP_RDID: begin
                state_d   = RESP;
                tx_d      = ID_CODE;
                rdsr_d    = 1'b0;
                out_cnt_d = 3'd0;
              end
              OP_WREN, OP_WRDI, OP_BE: ;
              default: state_d = IGNORE;
            endcase
          end
        end
      end
      RESP: begin
        if (sck_fall) begin
          miso_d    = tx_q[23];
          tx_d      = {tx_q[22:0], 1'b0};
          out_cnt_d = out_cnt_q + 3'd1;
          // RDSR streams: fetch live status as the last bit of each byte goes out.
          if (rdsr_q && out_cnt_q == 3'd7) tx_d = {status, 16'h0000};
        end
      end
      IGNORE: miso_d = 1'b0;
      default: state_d = IDLE;
    endcase

    if (cs_s1) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      miso_d    = 1'b0;
    end
  end

  assign miso      = miso_q;
  assign wel       = wel_q;
  assign wip       = wip_q;
  assign be_done   = be_done_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_byte  = cmd_byte_q;

endmodule

// File: tb/tb_spi_flash_resp.sv
// Scoreboard bench for spi_flash_resp: sys_clk 50 MHz, sck = sys_clk/4.
module tb_spi_flash_resp;
  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       miso, wel, wip, be_done, cmd_valid;
  logic [7:0] cmd_byte;

  spi_flash_resp #(.BE_CYCLES(32'd500), .ID_CODE(24'h202015)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cs_n(cs_n), .sck(sck), .mosi(mosi),
    .miso(miso), .wel(wel), .wip(wip), .be_done(be_done),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte)
  );

  always #10 sys_clk = ~sys_clk;

  int         n_checks = 0;
  int         n_pass = 0;
  int         done_cnt = 0;
  int         wip_len = 0;
  logic       prev_bd = 1'b0;
  logic       prev_cv = 1'b0;
  logic [7:0] exp_cmd_q[$];
  logic [7:0] exp_rx_q[$];
  int         exp_len_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic spi_bits(input logic [63:0] tx, input int nbits, output logic [63:0] rx);
    rx = '0;
    @(negedge sys_clk);
    cs_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[nbits-1-i];
      repeat (2) @(negedge sys_clk);
      sck = 1'b1;
      repeat (2) @(negedge sys_clk);
      rx = {rx[62:0], miso};
      sck = 1'b0;
    end
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic send(input logic [63:0] tx, input int nbits, output logic [63:0] rx);
    spi_bits(tx, nbits, rx);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (6) @(negedge sys_clk);
  endtask

  task automatic cmd(input logic [7:0] b);
    logic [63:0] rx;
    exp_cmd_q.push_back(b);
    send({56'h0, b}, 8, rx);
  endtask

  task automatic check_rx(input logic [63:0] rx, input int nbytes);
    for (int k = nbytes - 1; k >= 0; k--) begin
      if (exp_rx_q.size() == 0) check("rx_underflow", 32'd1, 32'd0);
      else check("miso_byte", {24'h0, rx[k*8 +: 8]}, {24'h0, exp_rx_q.pop_front()});
    end
  endtask

  task automatic wait_done(input int prev, input int budget);
    for (int i = 0; i < budget && done_cnt == prev; i++) @(negedge sys_clk);
    check("be_done_seen", done_cnt, prev + 1);
  endtask

  // Output monitor: pops the scoreboard on cmd_valid and be_done.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        wip_len = 0;
      end else begin
        if (cmd_valid) begin
          check("cmd_valid_width", {31'h0, prev_cv}, 32'd0);
          if (exp_cmd_q.size() == 0) check("cmd_unexpected", {24'h0, cmd_byte}, 32'hFFFF);
          else check("cmd_byte", {24'h0, cmd_byte}, {24'h0, exp_cmd_q.pop_front()});
        end
        if (wip) wip_len++;
        if (be_done) begin
          check("be_done_width", {31'h0, prev_bd}, 32'd0);
          if (exp_len_q.size() == 0) check("be_done_unexpected", 32'd1, 32'd0);
          else check("wip_len", wip_len, exp_len_q.pop_front());
          done_cnt++;
          wip_len = 0;
        end
      end
      prev_bd = be_done;
      prev_cv = cmd_valid;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d done", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rx;
    int d0;
    repeat (3) @(negedge sys_clk);
    check("rst_miso", {31'h0, miso}, 32'd0);
    check("rst_wel", {31'h0, wel}, 32'd0);
    check("rst_wip", {31'h0, wip}, 32'd0);
    check("rst_be_done", {31'h0, be_done}, 32'd0);
    check("rst_cmd_valid", {31'h0, cmd_valid}, 32'd0);
    check("rst_cmd_byte", {24'h0, cmd_byte}, 32'h00);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);

    // WREN: wel rises on the third sys_clk edge after cs_n goes high
    exp_cmd_q.push_back(8'h06);
    spi_bits(64'h06, 8, rx);
    cs_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("wel_early", {31'h0, wel}, 32'd0);
    @(negedge sys_clk);
    check("wel_set", {31'h0, wel}, 32'd1);
    check("wip_idle", {31'h0, wip}, 32'd0);
    repeat (6) @(negedge sys_clk);

    cmd(8'h04);
    check("wrdi_clears", {31'h0, wel}, 32'd0);

    // WREN plus a ninth clock is not executed
    exp_cmd_q.push_back(8'h06);
    send(64'h00D, 9, rx);
    check("wren_9bit", {31'h0, wel}, 32'd0);

    // BE without WREN
    d0 = done_cnt;
    cmd(8'hC7);
    repeat (20) @(negedge sys_clk);
    check("be_no_wel_wip", {31'h0, wip}, 32'd0);
    check("be_no_wel_byte", {24'h0, cmd_byte}, 32'hC7);
    check("be_no_wel_done", done_cnt, d0);

    // Full erase; monitor checks the wip duration
    cmd(8'h06);
    exp_len_q.push_back(500);
    d0 = done_cnt;
    cmd(8'hC7);
    check("erase_wip", {31'h0, wip}, 32'd1);
    wait_done(d0, 700);
    check("erase_end_wip", {31'h0, wip}, 32'd0);
    check("erase_end_wel", {31'h0, wel}, 32'd0);

    // Erase with a blocked WRDI and a streamed RDSR
    cmd(8'h06);
    exp_len_q.push_back(500);
    d0 = done_cnt;
    cmd(8'hC7);
    cmd(8'h04);
    exp_cmd_q.push_back(8'h05);
    for (int k = 0; k < 3; k++) exp_rx_q.push_back(8'h03);
    send({32'h0, 8'h05, 24'h0}, 32, rx);
    check_rx(rx, 3);
    wait_done(d0, 700);
    exp_cmd_q.push_back(8'h05);
    exp_rx_q.push_back(8'h00);
    send({48'h0, 8'h05, 8'h00}, 16, rx);
    check_rx(rx, 1);

    // RDID then zero fill
    exp_cmd_q.push_back(8'h9F);
    exp_rx_q.push_back(8'h20);
    exp_rx_q.push_back(8'h20);
    exp_rx_q.push_back(8'h15);
    exp_rx_q.push_back(8'h00);
    exp_rx_q.push_back(8'h00);
    send({16'h0, 8'h9F, 40'h0}, 48, rx);
    check_rx(rx, 5);

    // Unknown opcode is ignored
    exp_cmd_q.push_back(8'hAB);
    exp_rx_q.push_back(8'h00);
    exp_rx_q.push_back(8'h00);
    send({40'h0, 8'hAB, 16'hFFFF}, 24, rx);
    check_rx(rx, 2);
    check("unknown_wel", {31'h0, wel}, 32'd0);

    // Reset in the middle of an erase
    cmd(8'h06);
    d0 = done_cnt;
    cmd(8'hC7);
    repeat (194) @(negedge sys_clk);
    check("pre_rst_wip", {31'h0, wip}, 32'd1);
    #5 sys_rst = 1'b1;
    #1;
    check("arst_wip", {31'h0, wip}, 32'd0);
    check("arst_wel", {31'h0, wel}, 32'd0);
    check("arst_cmd_byte", {24'h0, cmd_byte}, 32'h00);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (600) @(negedge sys_clk);
    check("arst_no_done", done_cnt, d0);
    check("arst_wip_after", {31'h0, wip}, 32'd0);

    check("cmd_q_empty", exp_cmd_q.size(), 32'd0);
    check("rx_q_empty", exp_rx_q.size(), 32'd0);
    check("len_q_empty", exp_len_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
